instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Writer-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit instructions, most significant byte first. Each instruction is written to the instruction memory write port at consecutive word-aligned byte addresses. While loading it holds the CPU in reset. It sits between the host/test byte source and the instruction memory, replacing file-based preload for in-system programming.

## Interface
- `DEPTH`, default 32: instruction memory depth in words; also the maximum word count.
- `AW`, default 5: word-index width; must equal clog2(DEPTH).
- `clk_i` input, 1: clock; all state updates on the rising edge.
- `rst_i` input, 1: reset, asynchronous, active-high.
- `start_i` input, 1: single-cycle request to begin a load; sampled only in IDLE.
- `word_count_i` input, AW+1: number of words to load; sampled with `start_i`.
- `in_valid_i` input, 1: byte on `in_data_i` is valid.
- `in_data_i` input, 8: stream byte.
- `in_ready_o` output, 1: loader can accept a byte.
- `we_o` output, 1: instruction memory write enable; one-cycle pulse per word.
- `waddr_o` output, 32: byte address, equal to word index × 4. Bits [1:0] are always 0.
- `wdata_o` output, 32: assembled instruction.
- `busy_o` output, 1: load in progress.
- `cpu_hold_o` output, 1: CPU reset request; equal to `busy_o`.
- `done_o` output, 1: one-cycle pulse when the final word is written.
- `checksum_o` output, 32: mod-2^32 sum of all words written in the current load. Holds its value after the load completes.

## Operation
- States:
  - IDLE → LOAD on `start_i` when 1 ≤ `word_count_i` ≤ DEPTH.
  - LOAD → WRITE when the 4th byte of a word is accepted.
  - WRITE → LOAD if more words remain.
  - WRITE → IDLE after the last word; `done_o` pulses in this cycle.
- `start_i` with `word_count_i` = 0: no state change, and `done_o` pulses the next cycle. `checksum_o` clears to 0.
- `start_i` with `word_count_i` > DEPTH: ignored. The loader stays in IDLE with no pulse.
- On an accepted `start_i`:
  - the word index clears to 0;
  - the byte counter clears to 0;
  - `checksum_o` clears to 0;
  - `word_count_i` is latched.
- Handshake:
  - A byte transfers when `in_valid_i` && `in_ready_o`.
  - `in_ready_o` = 1 only in LOAD.
  - `in_valid_i` may stay high across WRITE without any byte loss.
- Byte assembly: shift register, shifting left 8 bits per accepted byte. The first byte accepted lands in [31:24].
- WRITE:
  - `we_o` = 1.
  - `waddr_o` = {index, 2'b00}, zero-extended to 32 bits.
  - `wdata_o` = the assembled word.
  - `checksum_o` += word, registered.
  - The index increments.
- `start_i` while busy: ignored.
- Reset mid-load: an asynchronous return to IDLE. The partial word is discarded. `we_o` deasserts immediately. Words already written are not rolled back.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready_o` = 0, `we_o` = 0, `busy_o` = 0, `cpu_hold_o` = 0, `done_o` = 0;
  - `waddr_o` = 0, `wdata_o` = 0, `checksum_o` = 0.
- `in_ready_o`, `busy_o` and `cpu_hold_o` rise in the cycle after an accepted `start_i`.
- With `in_valid_i` held high, each word takes 5 cycles: 4 accept cycles plus 1 WRITE cycle.
- `we_o` is asserted in the cycle after the 4th byte is accepted.
- Full-depth load: DEPTH × 5 cycles from the first ready to `done_o`.
- `done_o`: same cycle as the final `we_o`.
- `busy_o`: low the cycle after the final `we_o`.
- Outputs are registered. `in_ready_o` is decoded from the state register only and has no combinational path from `in_valid_i`.
- `waddr_o` and `wdata_o` hold their last written values outside WRITE.

## Structure
- The shared package `imem_pkg` holds:
  - the state enum (IDLE, LOAD, WRITE);
  - the DEPTH and AW defaults;
  - the bytes-per-word constant (4).
- Sub-module `byte_packer`: 8-to-32 shift register with a 2-bit byte counter, a `word_ready` strobe and a synchronous clear.
- The state machine, index counter and checksum stay in the top module.

## Test plan
- Reset then load 2 words with bytes 0x20,0x08,0x00,0x05,0x8C,0x01,0x00,0x04 and `in_valid_i` held high:
  - writes 0x20080005 at address 0 and 0x8C010004 at address 4;
  - `done_o` coincides with the 2nd `we_o`;
  - `checksum_o` = 0xAC090009.
- Full load of 32 words, data = index, with `in_valid_i` toggling randomly:
  - addresses run 0..124 in steps of 4;
  - no byte is lost or duplicated;
  - `busy_o` is high for exactly the load duration.
- `start_i` with `word_count_i` = 0 → `done_o` pulses the next cycle and `we_o` never asserts. `start_i` with `word_count_i` = 33 → nothing happens.
- `start_i` pulsed again mid-load → ignored; the word sequence continues unchanged.
- `rst_i` asserted after 2 bytes of word 3 → all outputs return to reset values asynchronously. A subsequent 1-word load writes address 0 with the new bytes only.
- A back-to-back second load → `checksum_o` restarts from 0 and the index restarts at 0.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory loader
//
// Purpose: state encoding, default geometry and word packing constants used by
//          instr_mem_loader and byte_packer.
// Ports:   none (package).
package imem_pkg;

    localparam int IMEM_DEPTH     = 32;
    localparam int IMEM_AW        = 5;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - 8-to-32 bit big-endian byte packer
//
// Purpose: shifts accepted bytes in from the right so the first byte of a word
//          ends up in [31:24]; flags the byte that completes a word.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous clear of byte counter and partial word
//   accept        a byte on data is taken this cycle
//   data          stream byte
//   word          assembled word, valid while word_ready is high
//   word_ready    strobe: this accept completes a word
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt;
    // Only the first three bytes need storage; the fourth is taken straight
    // from data so the word is available in the cycle it completes.
    logic [23:0] shift_q;

    assign word       = {shift_q, data};
    assign word_ready = accept && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {shift_q[15:0], data};
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader for the instruction memory
//
// Purpose: assembles a byte stream (MSB first) into 32-bit instructions and
//          writes them to consecutive word addresses, holding the CPU in reset
//          while a load is running.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i, word_count_i    load request and number of words (sampled in IDLE)
//   in_valid_i, in_data_i    byte stream input
//   in_ready_o               byte stream ready (LOAD state only)
//   we_o, waddr_o, wdata_o   instruction memory write port
//   busy_o, cpu_hold_o       load in progress / CPU reset request
//   done_o                   pulse on final write (or after a zero-length start)
//   checksum_o               mod-2^32 sum of words written by the current load
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW:0]   word_count_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          we_o,
    output logic [31:0]   waddr_o,
    output logic [31:0]   wdata_o,
    output logic          busy_o,
    output logic          cpu_hold_o,
    output logic          done_o,
    output logic [31:0]   checksum_o
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] index;
    logic [AW:0]   count;

    logic          accept;
    logic          start_load;
    logic          start_zero;
    logic          last_word;
    logic [31:0]   packed_word;
    logic          word_ready;

    assign accept     = (state == LOAD) && in_valid_i;
    assign start_zero = (state == IDLE) && start_i && (word_count_i == '0);
    assign start_load = (state == IDLE) && start_i && (word_count_i != '0)
                        && (word_count_i <= DEPTH_W);
    assign last_word  = ({1'b0, index} + (AW + 1)'(1)) == count;

    // Status outputs decode the state register only, so in_ready_o has no
    // path from in_valid_i and everything drops the moment rst_i rises.
    assign in_ready_o = (state == LOAD);
    assign we_o       = (state == WRITE);
    assign busy_o     = (state != IDLE);
    assign cpu_hold_o = busy_o;

    byte_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (start_load),
        .accept     (accept),
        .data       (in_data_i),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            index      <= '0;
            count      <= '0;
            done_o     <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            checksum_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_zero) begin
                        done_o     <= 1'b1;
                        checksum_o <= '0;
                    end else if (start_load) begin
                        state      <= LOAD;
                        index      <= '0;
                        count      <= word_count_i;
                        checksum_o <= '0;
                    end
                end
                LOAD: begin
                    // Write port and checksum are loaded on the way into WRITE
                    // so they are valid for the whole WRITE cycle.
                    if (word_ready) begin
                        state      <= WRITE;
                        waddr_o    <= 32'({index, 2'b00});
                        wdata_o    <= packed_word;
                        checksum_o <= checksum_o + packed_word;
                        done_o     <= last_word;
                    end
                end
                WRITE: begin
                    index <= index + AW'(1);
                    state <= last_word ? IDLE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW:0]   word_count_i = '0;
    logic          in_valid_i = 1'b0;
    logic [7:0]    in_data_i = '0;
    logic          in_ready_o, we_o, busy_o, cpu_hold_o, done_o;
    logic [31:0]   waddr_o, wdata_o, checksum_o;

    int total = 0;
    int bad   = 0;

    instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .busy_o       (busy_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .checksum_o   (checksum_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation records, sampled mid-cycle.
    word_q_t wa_q, wd_q;
    int done_n, done_cyc, we_cyc, busy_n, first_busy, last_busy, hold_bad, start_cyc;

    always @(negedge clk) begin
        if (we_o === 1'b1) begin
            wa_q.push_back(waddr_o);
            wd_q.push_back(wdata_o);
            we_cyc = cyc;
        end
        if (done_o === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy_o === 1'b1) begin
            busy_n++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        if (cpu_hold_o !== busy_o) hold_bad++;
    end

    // Reference: big-endian grouping of bytes into words.
    function automatic word_q_t model_words(byte_q_t b);
        word_q_t w;
        for (int k = 0; k + 3 < b.size(); k += 4)
            w.push_back(b[k] * 32'd16777216 + b[k+1] * 32'd65536 + b[k+2] * 32'd256 + 32'(b[k+3]));
        return w;
    endfunction

    function automatic logic [31:0] model_sum(word_q_t w);
        logic [31:0] s = 0;
        foreach (w[k]) s += w[k];
        return s;
    endfunction

    function automatic byte_q_t rand_bytes(int n);
        byte_q_t b;
        for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
        return b;
    endfunction

    // Drives one load; stops when done is seen with all bytes sent, after
    // abort_after accepted bytes, or when the cycle budget runs out.
    task automatic run_load(input int cnt, input byte_q_t b, input bit rnd,
                            input int restart_at, input int abort_after,
                            input int budget, output bit timed_out);
        int i = 0;
        @(negedge clk); #1;
        wa_q.delete(); wd_q.delete();
        done_n = 0; done_cyc = -1; we_cyc = -1; busy_n = 0;
        first_busy = -1; last_busy = -1; hold_bad = 0;
        start_i = 1'b1;
        word_count_i = (AW + 1)'(cnt);
        start_cyc = cyc;
        @(negedge clk); #1;
        start_i = 1'b0;
        timed_out = 1'b0;
        forever begin
            if (abort_after >= 0 && i == abort_after) break;
            if (done_n > 0 && i == b.size()) break;
            if (budget == 0) begin timed_out = 1'b1; break; end
            if (i < b.size()) begin
                in_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data_i  = b[i];
            end else begin
                in_valid_i = 1'b0;
            end
            if (restart_at >= 0 && i == restart_at) begin
                start_i = 1'b1;
                word_count_i = (AW + 1)'(3);
            end else begin
                start_i = 1'b0;
            end
            if (in_valid_i && in_ready_o) i++;
            @(negedge clk); #1;
            budget--;
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_o); end
        total++; if (we_o !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b exp=0", we_o); end
        total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (cpu_hold_o !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", cpu_hold_o); end
        total++; if (done_o !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
        total++; if (waddr_o !== 32'h0)   begin bad++; $display("FAIL reset_waddr got=%h exp=0", waddr_o); end
        total++; if (wdata_o !== 32'h0)   begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
        total++; if (checksum_o !== 32'h0) begin bad++; $display("FAIL reset_checksum got=%h exp=0", checksum_o); end
        rst_i = 1'b0;
    endtask

    // Checks recorded writes against the model for the given byte stream.
    task automatic check_writes(input string name, input byte_q_t b);
        word_q_t ew = model_words(b);
        total++;
        if (wa_q.size() != ew.size()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", name, wa_q.size(), ew.size());
        end else begin
            foreach (ew[k]) begin
                total++;
                if (wa_q[k] !== 32'(k * 4) || wd_q[k] !== ew[k]) begin
                    bad++;
                    $display("FAIL %s_word%0d got=%h@%h exp=%h@%h", name, k, wd_q[k], wa_q[k], ew[k], k * 4);
                end
            end
        end
        total++;
        if (checksum_o !== model_sum(ew)) begin
            bad++; $display("FAIL %s_checksum got=%h exp=%h", name, checksum_o, model_sum(ew));
        end
        total++;
        if (done_n != 1 || done_cyc != we_cyc) begin
            bad++; $display("FAIL %s_done got=%0d@%0d exp=1@%0d", name, done_n, done_cyc, we_cyc);
        end
        total++;
        if (first_busy != start_cyc + 1 || last_busy != done_cyc || busy_n != done_cyc - start_cyc || hold_bad != 0) begin
            bad++;
            $display("FAIL %s_busy got=%0d cycles from %0d to %0d hold_bad=%0d exp=%0d cycles from %0d to %0d",
                     name, busy_n, first_busy, last_busy, hold_bad, done_cyc - start_cyc, start_cyc + 1, done_cyc);
        end
    endtask

    task automatic test_two_words();
        byte_q_t b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
        bit to;
        run_load(2, b, 1'b0, -1, -1, 200, to);
        total++; if (to) begin bad++; $display("FAIL two_timeout got=timeout exp=done"); end
        check_writes("two", b);
        total++;
        if (wd_q.size() == 2 && (wd_q[0] !== 32'h20080005 || wd_q[1] !== 32'h8C010004)) begin
            bad++; $display("FAIL two_literal got=%h,%h exp=20080005,8c010004", wd_q[0], wd_q[1]);
        end
        total++; if (checksum_o !== 32'hAC090009) begin bad++; $display("FAIL two_sum got=%h exp=ac090009", checksum_o); end
        total++; if (busy_n != 10) begin bad++; $display("FAIL two_cycles got=%0d exp=10", busy_n); end
    endtask

    task automatic test_full_depth();
        byte_q_t b;
        bit to;
        for (int k = 0; k < DEPTH; k++) begin
            b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'(k));
        end
        run_load(DEPTH, b, 1'b1, -1, -1, 4000, to);
        total++; if (to) begin bad++; $display("FAIL full_timeout got=timeout exp=done"); end
        check_writes("full", b);
        total++; if (checksum_o !== 32'd496) begin bad++; $display("FAIL full_sum got=%0d exp=496", checksum_o); end
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, DEPTH);
            byte_q_t b = rand_bytes(n * 4);
            bit to;
            run_load(n, b, 1'b1, -1, -1, 4000, to);
            total++; if (to) begin bad++; $display("FAIL rand%0d_timeout got=timeout exp=done", r); end
            check_writes($sformatf("rand%0d", r), b);
        end
    endtask

    task automatic test_count_edges();
        byte_q_t none;
        logic [31:0] prev_sum = checksum_o;
        bit to;
        run_load(DEPTH + 1, none, 1'b0, -1, -1, 10, to);
        total++;
        if (done_n != 0 || busy_n != 0 || wa_q.size() != 0 || checksum_o !== prev_sum) begin
            bad++; $display("FAIL over_depth got=done%0d busy%0d we%0d sum=%h exp=0,0,0 sum=%h",
                            done_n, busy_n, wa_q.size(), checksum_o, prev_sum);
        end
        run_load(0, none, 1'b0, -1, -1, 10, to);
        total++;
        if (to || done_n != 1 || done_cyc != start_cyc + 1) begin
            bad++; $display("FAIL zero_done got=%0d@%0d exp=1@%0d", done_n, done_cyc, start_cyc + 1);
        end
        total++;
        if (busy_n != 0 || wa_q.size() != 0 || checksum_o !== 32'h0) begin
            bad++; $display("FAIL zero_side got=busy%0d we%0d sum=%h exp=0,0,0", busy_n, wa_q.size(), checksum_o);
        end
    endtask

    task automatic test_restart_ignored();
        byte_q_t b = rand_bytes(16);
        bit to;
        run_load(4, b, 1'b0, 6, -1, 400, to);
        total++; if (to) begin bad++; $display("FAIL restart_timeout got=timeout exp=done"); end
        check_writes("restart", b);
    endtask

    task automatic test_reset_mid();
        byte_q_t b = rand_bytes(16);
        byte_q_t b2 = rand_bytes(4);
        byte_q_t first_two;
        bit to;
        for (int k = 0; k < 8; k++) first_two.push_back(b[k]);
        run_load(4, b, 1'b1, -1, 10, 400, to);
        #1 rst_i = 1'b1;
        #1;
        total++;
        if (in_ready_o !== 1'b0 || we_o !== 1'b0 || busy_o !== 1'b0 || cpu_hold_o !== 1'b0 || done_o !== 1'b0 ||
            waddr_o !== 32'h0 || wdata_o !== 32'h0 || checksum_o !== 32'h0) begin
            bad++; $display("FAIL midreset_outputs got=rdy%b we%b busy%b hold%b done%b a=%h d=%h s=%h exp=all zero",
                            in_ready_o, we_o, busy_o, cpu_hold_o, done_o, waddr_o, wdata_o, checksum_o);
        end
        total++;
        if (to || wd_q.size() != 2 || wd_q[0] !== model_words(first_two)[0] || wd_q[1] !== model_words(first_two)[1]) begin
            bad++; $display("FAIL midreset_prior got=%0d writes exp=2 matching", wd_q.size());
        end
        @(negedge clk); #1 rst_i = 1'b0;
        run_load(1, b2, 1'b0, -1, -1, 100, to);
        total++; if (to) begin bad++; $display("FAIL after_reset_timeout got=timeout exp=done"); end
        check_writes("after_reset", b2);
    endtask

    task automatic test_back_to_back();
        byte_q_t b1 = rand_bytes(12);
        byte_q_t b2 = rand_bytes(8);
        bit to;
        run_load(3, b1, 1'b0, -1, -1, 200, to);
        total++; if (to) begin bad++; $display("FAIL b2b_first_timeout got=timeout exp=done"); end
        check_writes("b2b_first", b1);
        run_load(2, b2, 1'b1, -1, -1, 400, to);
        total++; if (to) begin bad++; $display("FAIL b2b_second_timeout got=timeout exp=done"); end
        check_writes("b2b_second", b2);
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_full_depth();
        test_random_loads();
        test_count_edges();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
